// File: rtl/alu_pkg.sv
// Shared definitions for the ALU responder: op codes, handshake FSM states
// and bit positions inside the {Z, C, V, N} flag vector.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_ROL   = 4'h8;
    localparam logic [3:0] OP_ROR   = 4'h9;
    localparam logic [3:0] OP_INC   = 4'hA;
    localparam logic [3:0] OP_DEC   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_DIV   = 4'hD;
    localparam logic [3:0] OP_CMP   = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_V = 1;
    localparam int F_N = 0;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per clock.
// done/out are combinational views of the final step so the parent captures them on that edge.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ITER_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    logic                  run_reg;
    logic                  div_reg;
    logic [ITER_CNT_W-1:0] cnt_reg;
    logic [2*WIDTH-1:0]    work_reg;
    logic [WIDTH-1:0]      opb_reg;

    logic [WIDTH:0]        mul_sum;
    logic [2*WIDTH-1:0]    mul_next;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH:0]        div_diff;
    logic                  div_fits;
    logic [WIDTH-1:0]      div_rem;
    logic [2*WIDTH-1:0]    div_next;
    logic [2*WIDTH-1:0]    step_next;

    // work_reg holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, opb_reg} : '0);
        mul_next  = {mul_sum, work_reg[WIDTH-1:1]};
        div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_reg};
        div_fits  = ~div_diff[WIDTH];
        div_rem   = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {div_rem, work_reg[WIDTH-2:0], div_fits};
        step_next = div_reg ? div_next : mul_next;
    end

    assign done = run_reg && (cnt_reg == ITER_CNT_W'(1));
    assign out  = step_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_reg  <= 1'b0;
            div_reg  <= 1'b0;
            cnt_reg  <= '0;
            work_reg <= '0;
            opb_reg  <= '0;
        end else if (start) begin
            run_reg  <= 1'b1;
            div_reg  <= is_div;
            cnt_reg  <= ITER_CNT_W'(WIDTH);
            work_reg <= {{WIDTH{1'b0}}, op_a};
            opb_reg  <= op_b;
        end else if (run_reg) begin
            work_reg <= step_next;
            cnt_reg  <= cnt_reg - ITER_CNT_W'(1);
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_responder.sv
// ALU side of the alu_en/alu_done handshake: single-cycle ops complete on the accepting
// edge, MUL/DIV run through the iterative datapath; owns the flags and the accumulator.
module alu_responder
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ITER_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           op,
    input  logic                 alu_en,
    input  logic                 acc,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 div_zero,
    output logic                 busy,
    output logic                 alu_done
);

    state_t               state_reg;
    logic [WIDTH-1:0]     acc_reg;
    logic                 is_mul_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic [3:0]           flags_reg;
    logic                 div_zero_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic [WIDTH-1:0]     op_a;
    logic                 is_mul;
    logic                 is_div;
    logic                 div_by_zero;
    logic                 md_start;
    logic                 md_done;
    logic [2*WIDTH-1:0]   md_out;

    logic [WIDTH-1:0]     sc_res;
    logic [WIDTH-1:0]     sc_hi;
    logic                 sc_c;
    logic                 sc_v;

    assign op_a        = acc ? acc_reg : a;
    assign is_mul      = (op == OP_MUL);
    assign is_div      = (op == OP_DIV);
    assign div_by_zero = (b == '0);
    // Divide by zero never iterates; it is finished by the single-cycle path.
    assign md_start    = (state_reg == ST_IDLE) && alu_en && (is_mul || (is_div && !div_by_zero));

    alu_muldiv_seq #(
        .WIDTH      (WIDTH),
        .ITER_CNT_W (ITER_CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (is_div),
        .op_a   (op_a),
        .op_b   (b),
        .done   (md_done),
        .out    (md_out)
    );

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_ADD: begin
                {sc_c, sc_res} = {1'b0, op_a} + {1'b0, b};
                sc_v = (op_a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                {sc_c, sc_res} = {1'b0, op_a} - {1'b0, b};
                sc_v = (op_a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:   sc_res = op_a & b;
            OP_OR:    sc_res = op_a | b;
            OP_XOR:   sc_res = op_a ^ b;
            OP_NOT:   sc_res = ~op_a;
            OP_SHL: begin
                sc_res = {op_a[WIDTH-2:0], 1'b0};
                sc_c   = op_a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, op_a[WIDTH-1:1]};
                sc_c   = op_a[0];
            end
            OP_ROL: begin
                sc_res = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
                sc_c   = op_a[WIDTH-1];
            end
            OP_ROR: begin
                sc_res = {op_a[0], op_a[WIDTH-1:1]};
                sc_c   = op_a[0];
            end
            OP_INC: begin
                {sc_c, sc_res} = {1'b0, op_a} + (WIDTH+1)'(1);
                sc_v = (op_a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_DEC: begin
                {sc_c, sc_res} = {1'b0, op_a} - (WIDTH+1)'(1);
                sc_v = (op_a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = op_a;
                sc_c   = 1'b1;
            end
            OP_PASSB: sc_res = b;
            default:  sc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            is_mul_reg   <= 1'b0;
            result_reg   <= '0;
            flags_reg    <= '0;
            div_zero_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (alu_en) begin
                        div_zero_reg <= is_div && div_by_zero;
                        is_mul_reg   <= is_mul;
                        if (md_start) begin
                            state_reg <= ST_EXEC;
                            busy_reg  <= 1'b1;
                        end else begin
                            done_reg       <= 1'b1;
                            flags_reg[F_Z] <= (sc_res == '0);
                            flags_reg[F_C] <= sc_c;
                            flags_reg[F_V] <= sc_v;
                            flags_reg[F_N] <= sc_res[WIDTH-1];
                            // CMP only reports flags; result and accumulator stay put.
                            if (op != OP_CMP) begin
                                result_reg <= {sc_hi, sc_res};
                                acc_reg    <= sc_res;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    if (md_done) begin
                        state_reg      <= ST_IDLE;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        result_reg     <= md_out;
                        acc_reg        <= md_out[WIDTH-1:0];
                        flags_reg[F_Z] <= (md_out[WIDTH-1:0] == '0);
                        flags_reg[F_C] <= is_mul_reg && (md_out[2*WIDTH-1:WIDTH] != '0);
                        flags_reg[F_V] <= 1'b0;
                        flags_reg[F_N] <= md_out[WIDTH-1];
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign result   = result_reg;
    assign flags    = flags_reg;
    assign div_zero = div_zero_reg;
    assign busy     = busy_reg;
    assign alu_done = done_reg;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed vector table, handshake corner
// sequences, then random ops against an arithmetic reference model.
module tb_alu_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic        alu_en;
    logic        acc;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        div_zero;
    logic        busy;
    logic        alu_done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  model_acc;
    logic [15:0] model_res;

    always #5 clk = ~clk;

    alu_responder #(.WIDTH(8), .ITER_CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .alu_en   (alu_en),
        .acc      (acc),
        .result   (result),
        .flags    (flags),
        .div_zero (div_zero),
        .busy     (busy),
        .alu_done (alu_done)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic        accs;
        logic [15:0] res;
        logic [3:0]  fl;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        logic        dz;
        int          lat;
        logic [7:0]  acc_next;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference computed from the op definitions with plain integer arithmetic.
    function automatic exp_t ref_model(input int ai, input int bi, input int opi, input bit accsel,
                                       input int accum, input logic [15:0] prev);
        exp_t e;
        int A, B, sa, sb, low, hi, full;
        bit c, v;
        A = accsel ? accum : ai;
        B = bi;
        sa = (A >= 128) ? A - 256 : A;
        sb = (B >= 128) ? B - 256 : B;
        low = 0; hi = 0; c = 0; v = 0;
        e.lat = 1; e.dz = 0;
        case (opi)
            0: begin full = A + B; low = full % 256; c = full > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            1, 14: begin low = (A - B + 256) % 256; c = A < B; v = (sa - sb > 127) || (sa - sb < -128); end
            2: low = A & B;
            3: low = A | B;
            4: low = A ^ B;
            5: low = 255 - A;
            6: begin low = (A * 2) % 256; c = A >= 128; end
            7: begin low = A / 2; c = (A % 2) == 1; end
            8: begin low = (A * 2) % 256 + A / 128; c = A >= 128; end
            9: begin low = A / 2 + (A % 2) * 128; c = (A % 2) == 1; end
            10: begin low = (A + 1) % 256; c = A == 255; v = A == 127; end
            11: begin low = (A + 255) % 256; c = A == 0; v = A == 128; end
            12: begin full = A * B; low = full % 256; hi = full / 256; c = full > 255; e.lat = 9; end
            13: begin
                if (B == 0) begin low = 255; hi = A; c = 1; e.dz = 1; end
                else begin low = A / B; hi = A % B; e.lat = 9; end
            end
            default: low = B;
        endcase
        e.res = (opi == 14) ? prev : 16'(hi * 256 + low);
        e.fl = {(low == 0), c, v, (low >= 128)};
        e.acc_next = (opi == 14) ? 8'(accum) : 8'(low);
        return e;
    endfunction

    // Issue one op from a position #1 after a rising edge; returns observed latency in edges.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop, input logic iacc,
                         output logic [15:0] ores, output logic [3:0] ofl, output logic odz,
                         output int olat, output logic obusy);
        a = ia; b = ib; op = iop; acc = iacc; alu_en = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0;
        olat = 1;
        obusy = busy;
        while (!alu_done && olat < 20) begin
            @(posedge clk); #1;
            olat++;
        end
        ores = result; ofl = flags; odz = div_zero;
        @(posedge clk); #1;
        check("done_single_cycle", {31'b0, alu_done}, 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        logic [15:0] r16;
        logic [3:0]  f4;
        logic        dz;
        int          lat;
        logic        bz;
        exp_t        e;
        int          ndone;

        vecs[0]  = '{8'h30, 8'h1D, 4'h0, 1'b0, 16'h004D, 4'b0000, 1'b0, 1};
        vecs[1]  = '{8'h30, 8'h1D, 4'h1, 1'b0, 16'h0013, 4'b0000, 1'b0, 1};
        vecs[2]  = '{8'h30, 8'h20, 4'h1, 1'b1, 16'h00F3, 4'b0101, 1'b0, 1};
        vecs[3]  = '{8'h30, 8'h1D, 4'hC, 1'b0, 16'h0570, 4'b0100, 1'b0, 9};
        vecs[4]  = '{8'h30, 8'h1D, 4'hD, 1'b0, 16'h1301, 4'b0000, 1'b0, 9};
        vecs[5]  = '{8'h30, 8'h00, 4'hD, 1'b0, 16'h30FF, 4'b0101, 1'b1, 1};
        vecs[6]  = '{8'h7F, 8'h01, 4'h0, 1'b0, 16'h0080, 4'b0011, 1'b0, 1};
        vecs[7]  = '{8'h05, 8'h05, 4'hE, 1'b0, 16'h0080, 4'b1000, 1'b0, 1};
        vecs[8]  = '{8'h00, 8'h00, 4'h0, 1'b1, 16'h0080, 4'b0001, 1'b0, 1};
        vecs[9]  = '{8'hFF, 8'h00, 4'hA, 1'b0, 16'h0000, 4'b1100, 1'b0, 1};
        vecs[10] = '{8'h80, 8'h00, 4'hB, 1'b0, 16'h007F, 4'b0010, 1'b0, 1};
        vecs[11] = '{8'h01, 8'h00, 4'h9, 1'b0, 16'h0080, 4'b0101, 1'b0, 1};
        vecs[12] = '{8'h01, 8'h00, 4'h7, 1'b0, 16'h0000, 4'b1100, 1'b0, 1};
        vecs[13] = '{8'hFF, 8'hFF, 4'hC, 1'b0, 16'hFE01, 4'b0100, 1'b0, 9};
        vecs[14] = '{8'hFF, 8'h10, 4'hD, 1'b0, 16'h0F0F, 4'b0000, 1'b0, 9};
        vecs[15] = '{8'h81, 8'h00, 4'h8, 1'b0, 16'h0003, 4'b0100, 1'b0, 1};

        rst = 1'b1; a = '0; b = '0; op = '0; alu_en = 1'b0; acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_result", {16'b0, result}, 32'd0);
        check("reset_flags", {28'b0, flags}, 32'd0);
        check("reset_div_zero", {31'b0, div_zero}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, alu_done}, 32'd0);
        model_acc = '0;
        model_res = '0;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].accs, r16, f4, dz, lat, bz);
            $display("[TB] vec %0d op=%h a=%h b=%h acc=%0d -> result=%h flags=%b dz=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].accs, r16, f4, dz, lat);
            check($sformatf("vec%0d_result", i), {16'b0, r16}, {16'b0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {28'b0, f4}, {28'b0, vecs[i].fl});
            check($sformatf("vec%0d_div_zero", i), {31'b0, dz}, {31'b0, vecs[i].dz});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy", i), {31'b0, bz}, {31'b0, (vecs[i].lat > 1)});
            e = ref_model(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].accs, model_acc, model_res);
            model_acc = e.acc_next;
            model_res = r16;
        end

        // MUL with a second alu_en pulse during EXEC: it must be dropped, not queued.
        a = 8'h30; b = 8'h1D; op = 4'hC; acc = 1'b0; alu_en = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0;
        @(posedge clk); #1;
        check("exec_busy", {31'b0, busy}, 32'd1);
        op = 4'h0; alu_en = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0;
        lat = 3;
        while (!alu_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] mul with ignored alu_en -> result=%h lat=%0d", result, lat);
        check("exec_ignore_latency", lat, 9);
        check("exec_ignore_result", {16'b0, result}, 32'h0570);
        ndone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (alu_done) ndone++;
        end
        check("exec_ignore_no_queue", ndone, 0);
        model_acc = 8'h70;
        model_res = 16'h0570;

        // Reset asserted on edge 4 of a MUL aborts it without a completion.
        a = 8'h30; b = 8'h1D; op = 4'hC; acc = 1'b0; alu_en = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_result", {16'b0, result}, 32'd0);
        check("abort_flags", {28'b0, flags}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, alu_done}, 32'd0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (alu_done) ndone++;
        end
        $display("[TB] reset during MUL -> stray completions=%0d", ndone);
        check("abort_no_done", ndone, 0);
        model_acc = '0;
        model_res = '0;
        do_op(8'hAA, 8'h05, 4'h0, 1'b1, r16, f4, dz, lat, bz);
        $display("[TB] post-reset acc+5 -> result=%h lat=%0d", r16, lat);
        check("abort_acc_cleared", {16'b0, r16}, 32'h0005);
        check("abort_next_latency", lat, 1);
        model_acc = 8'h05;
        model_res = 16'h0005;

        // alu_en held high with single-cycle ops: one completion per edge.
        a = 8'h00; b = 8'h00; op = 4'hA; acc = 1'b1; alu_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            $display("[TB] back-to-back INC %0d -> result=%h done=%0d", k, result, alu_done);
            check($sformatf("b2b_done%0d", k), {31'b0, alu_done}, 32'd1);
            check($sformatf("b2b_result%0d", k), {16'b0, result}, 32'(5 + k));
        end
        alu_en = 1'b0;
        @(posedge clk); #1;
        check("b2b_done_drop", {31'b0, alu_done}, 32'd0);
        model_acc = 8'h08;
        model_res = 16'h0008;

        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rop;
            logic       racc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            racc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rb = 8'h00;
            e = ref_model(ra, rb, rop, racc, model_acc, model_res);
            do_op(ra, rb, rop, racc, r16, f4, dz, lat, bz);
            $display("[TB] rnd %0d op=%h a=%h b=%h acc=%0d -> result=%h flags=%b dz=%0d lat=%0d",
                     i, rop, ra, rb, racc, r16, f4, dz, lat);
            check($sformatf("rnd%0d_result", i), {16'b0, r16}, {16'b0, e.res});
            check($sformatf("rnd%0d_flags", i), {28'b0, f4}, {28'b0, e.fl});
            check($sformatf("rnd%0d_div_zero", i), {31'b0, dz}, {31'b0, e.dz});
            check($sformatf("rnd%0d_latency", i), lat, e.lat);
            model_acc = e.acc_next;
            model_res = e.res;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
